// File: rtl/seg_scan_scheduler.sv
// Eight-digit seven-segment scan scheduler: double-buffered frames, per-slot blanking and PWM brightness.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_scheduler #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned NUM_DIGITS   = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_frame_digits,
  input  logic [NUM_DIGITS-1:0]   i_frame_dots,
  input  logic                    i_frame_valid,
  output logic                    o_frame_ready,
  input  logic [3:0]              i_brightness,
  output logic [3:0]              o_digit,
  output logic                    o_dot,
  output logic [2:0]              o_digit_sel,
  output logic                    o_digit_on,
  output logic                    o_frame_done
);

  localparam int unsigned DW         = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W      = $clog2(TICK_DIV);
  localparam int unsigned ACTIVE_LEN = TICK_DIV - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       SEL_LAST   = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON, DARK} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  on_len;
  logic [CNT_W-1:0]  on_last;
  logic [2:0]        sel, next_sel;
  logic [DW-1:0]     active_digits, shadow_digits, next_digits;
  logic [NUM_DIGITS-1:0] active_dots, shadow_dots, next_dots;
  logic              shadow_full, next_shadow_full;
  logic              xfer, load_idle, slot_end, wrap, promote;
  logic [31:0]       digit_pad;
  logic [7:0]        dot_pad;
  logic [7:0]        next_mask;
  logic              next_on;

  // Lit window length for a brightness code: (active part of slot) * (b+1) / 16.
  function automatic logic [CNT_W-1:0] calc_on_len(input logic [3:0] b);
    return CNT_W'((ACTIVE_LEN * (32'(b) + 32'd1)) >> 4);
  endfunction

`ifdef SEG_LZB_EN
  logic [7:0] mask;

  // Mask the run of blank (zero nibble, no dot) digits from the top; digit 0 always lights.
  function automatic logic [7:0] lzb_mask(input logic [DW-1:0] d, input logic [NUM_DIGITS-1:0] p);
    logic [7:0] m;
    logic       stop;
    m    = '0;
    stop = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      if (!stop && d[4*k +: 4] == 4'd0 && !p[k]) m[k] = 1'b1;
      else stop = 1'b1;
    end
    return m;
  endfunction
`endif

  // Next-state, buffer and output selection.
  always_comb begin
    xfer             = i_frame_valid & o_frame_ready;
    load_idle        = (state == IDLE) && xfer;
    slot_end         = (state != IDLE) && (cnt == SLOT_LAST);
    wrap             = slot_end && (sel == SEL_LAST);
    promote          = wrap && shadow_full;
    on_last          = BLANK_LAST + on_len;
    next_state       = state;
    next_sel         = sel;
    next_digits      = active_digits;
    next_dots        = active_dots;
    next_shadow_full = shadow_full;
    next_mask        = '0;

    if (load_idle) begin
      next_digits = i_frame_digits;
      next_dots   = i_frame_dots;
    end else if (promote) begin
      next_digits = shadow_digits;
      next_dots   = shadow_dots;
    end

    if (load_idle) next_sel = 3'd0;
    else if (slot_end) next_sel = wrap ? 3'd0 : sel + 3'd1;

    if (promote) next_shadow_full = 1'b0;
    else if (xfer && state != IDLE) next_shadow_full = 1'b1;

    case (state)
      IDLE:    if (load_idle) next_state = BLANK;
      BLANK:   if (cnt == BLANK_LAST) next_state = ON;
      ON:      if (slot_end) next_state = BLANK;
               else if (cnt == on_last) next_state = DARK;
      DARK:    if (slot_end) next_state = BLANK;
      default: next_state = IDLE;
    endcase

`ifdef SEG_LZB_EN
    next_mask = (load_idle || promote) ? lzb_mask(next_digits, next_dots) : mask;
`endif

    digit_pad = 32'(next_digits);
    dot_pad   = 8'(next_dots);
    next_on   = (next_state == ON) && !next_mask[next_sel];
  end

  // State, counters, buffers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      on_len        <= '0;
      sel           <= 3'd0;
      active_digits <= '0;
      active_dots   <= '0;
      shadow_digits <= '0;
      shadow_dots   <= '0;
      shadow_full   <= 1'b0;
      o_frame_ready <= 1'b1;
      o_digit       <= 4'd0;
      o_dot         <= 1'b0;
      o_digit_sel   <= 3'd0;
      o_digit_on    <= 1'b0;
      o_frame_done  <= 1'b0;
`ifdef SEG_LZB_EN
      mask          <= '0;
`endif
    end else begin
      state         <= next_state;
      sel           <= next_sel;
      active_digits <= next_digits;
      active_dots   <= next_dots;
      shadow_full   <= next_shadow_full;
      if (load_idle || slot_end) begin
        cnt    <= '0;
        on_len <= calc_on_len(i_brightness);
      end else if (state != IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (xfer && state != IDLE) begin
        shadow_digits <= i_frame_digits;
        shadow_dots   <= i_frame_dots;
      end
      o_frame_ready <= !next_shadow_full;
      o_digit       <= digit_pad[{next_sel, 2'b00} +: 4];
      o_dot         <= dot_pad[next_sel];
      o_digit_sel   <= next_sel;
      o_digit_on    <= next_on;
      o_frame_done  <= wrap;
`ifdef SEG_LZB_EN
      mask          <= next_mask;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler (TICK_DIV=20, BLANK_CYCLES=4, NUM_DIGITS=8) with a
// cycle-position model of the scan and a per-cycle output comparison.
module tb_seg_scan_scheduler;

  localparam int TD = 20;
  localparam int BL = 4;
  localparam int ND = 8;
  localparam int FRAME = TD * ND;

  logic        clk;
  logic        rst;
  logic [31:0] frame_digits;
  logic [7:0]  frame_dots;
  logic        frame_valid;
  logic        frame_ready;
  logic [3:0]  brightness;
  logic [3:0]  digit;
  logic        dot;
  logic [2:0]  digit_sel;
  logic        digit_on;
  logic        frame_done;

  seg_scan_scheduler #(.TICK_DIV(TD), .BLANK_CYCLES(BL), .NUM_DIGITS(ND)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_frame_digits(frame_digits), .i_frame_dots(frame_dots),
    .i_frame_valid(frame_valid), .o_frame_ready(frame_ready),
    .i_brightness(brightness),
    .o_digit(digit), .o_dot(dot), .o_digit_sel(digit_sel),
    .o_digit_on(digit_on), .o_frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position inside the 160-cycle scan, the displayed frame and a one-deep pending frame.
  bit          m_run, m_pend, m_done;
  int          m_cyc, m_b;
  logic [31:0] m_act_d, m_sh_d;
  logic [7:0]  m_act_p, m_sh_p;
  bit          m_xfer;

  function automatic bit masked(input int s);
`ifdef SEG_LZB_EN
    return (s != 0) && ((m_act_d >> (4 * s)) == 32'd0) && ((m_act_p >> s) == 8'd0);
`else
    return (s < 0);
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_pend = 0; m_done = 0; m_cyc = 0; m_b = 0;
      m_act_d = '0; m_act_p = '0; m_sh_d = '0; m_sh_p = '0;
    end else begin
      m_done = 0;
      m_xfer = frame_valid && !m_pend;
      if (!m_run) begin
        if (m_xfer) begin
          m_act_d = frame_digits; m_act_p = frame_dots;
          m_run = 1; m_cyc = 0; m_b = int'(brightness);
        end
      end else begin
        m_cyc = (m_cyc + 1) % FRAME;
        if (m_cyc % TD == 0) m_b = int'(brightness);
        if (m_cyc == 0) begin
          m_done = 1;
          if (m_pend) begin m_act_d = m_sh_d; m_act_p = m_sh_p; m_pend = 0; end
        end
        if (m_xfer) begin m_sh_d = frame_digits; m_sh_p = frame_dots; m_pend = 1; end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    int e_sel, off, onl;
    bit e_on;
    @(negedge clk);
    if (chk_en) begin
      e_sel = m_run ? m_cyc / TD : 0;
      off   = m_cyc % TD;
      onl   = ((TD - BL) * (m_b + 1)) >> 4;
      e_on  = m_run && off >= BL && off < BL + onl && !masked(e_sel);
      chk("sel",   int'(digit_sel),   e_sel);
      chk("digit", int'(digit),       int'((m_act_d >> (4 * e_sel)) & 32'hF));
      chk("dot",   int'(dot),         int'((m_act_p >> e_sel) & 8'h1));
      chk("on",    int'(digit_on),    int'(e_on));
      chk("done",  int'(frame_done),  int'(m_done));
      chk("ready", int'(frame_ready), int'(!m_pend));
    end
  end

  task automatic wait_sel(input int s, input int budget);
    int n = 0;
    while (int'(digit_sel) != s && n < budget) begin @(negedge clk); n++; end
    chk("wait_sel", int'(digit_sel), s);
  endtask

  task automatic wait_on(input int v, input int budget);
    int n = 0;
    while (int'(digit_on) != v && n < budget) begin @(negedge clk); n++; end
    chk("wait_on", int'(digit_on), v);
  endtask

  task automatic count_lit(input int cycles, output int lit, output int done);
    lit = 0; done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      lit += int'(digit_on);
      done += int'(frame_done);
    end
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] p);
    frame_digits = d; frame_dots = p; frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  initial begin
    int lit, done, run;
    rst = 1'b1; frame_valid = 1'b0; frame_digits = '0; frame_dots = '0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", int'(frame_ready), 1);
    chk("rst_sel", int'(digit_sel), 0);
    chk("rst_on", int'(digit_on), 0);
    rst = 1'b0;

    // Idle: nothing lights without a frame.
    count_lit(500, lit, done);
    chk("idle_lit", lit, 0);
    chk("idle_sel", int'(digit_sel), 0);

    // Full brightness frame.
    offer(32'h7654_3210, 8'h22);
    chk("load_ready", int'(frame_ready), 1);
    chk("load_on", int'(digit_on), 0);
    repeat (19) @(negedge clk);
    count_lit(FRAME, lit, done);
    chk("b15_lit", lit, 128);
    chk("b15_done", done, 1);
    wait_sel(1, 200);
    wait_on(1, 40);
    chk("sel1_dot", int'(dot), 1);
    chk("sel1_digit", int'(digit), 1);

    // Brightness 3, then a mid-slot change that must not stretch the current window.
    brightness = 4'd3;
    repeat (40) @(negedge clk);
    count_lit(FRAME, lit, done);
    chk("b3_lit", lit, 32);
    wait_on(0, 40);
    wait_on(1, 40);
    brightness = 4'd15;
    run = 0;
    while (digit_on && run < 40) begin run++; @(negedge clk); end
    chk("b3_run", run, 4);

    // Double-buffered frame offered mid-scan.
    wait_sel(3, 200);
    offer(32'h89AB_CDEF, 8'h00);
    chk("pend_ready", int'(frame_ready), 0);
    wait_sel(0, 200);
    chk("swap_digit", int'(digit), 15);
    chk("swap_ready", int'(frame_ready), 1);

    // Transfer on the wrap edge is held for one full frame.
    wait_sel(7, 200);
    repeat (TD - 1) @(negedge clk);
    offer(32'h1357_2468, 8'h81);
    chk("wrapx_sel", int'(digit_sel), 0);
    chk("wrapx_digit", int'(digit), 15);
    chk("wrapx_ready", int'(frame_ready), 0);
    wait_sel(1, 200);
    wait_sel(0, 200);
    chk("late_digit", int'(digit), 8);
    chk("late_dot", int'(dot), 1);

    // Reset during a lit window, then a frame with leading zeros.
    wait_on(1, 40);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_on", int'(digit_on), 0);
    chk("mid_rst_sel", int'(digit_sel), 0);
    chk("mid_rst_digit", int'(digit), 0);
    rst = 1'b0;
    @(negedge clk);
    offer(32'h0000_0120, 8'h00);
    repeat (19) @(negedge clk);
    count_lit(FRAME, lit, done);
`ifdef SEG_LZB_EN
    chk("lzb_lit", lit, 48);
`else
    chk("lzb_lit", lit, 128);
`endif

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
